uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART serial line between `NUM_REQ` byte producers. The block arbitrates round-robin, accepts one byte per frame over a valid/ready handshake, and serializes it onto `tx`. Each bit is held for `OVERSAMPLE` clocks, and frames use the team's format: start, 8 data bits LSB first, optional parity, two stop bits, then one idle guard bit. It sits between the test/stimulus side and the DUT's UART receive input.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `OVERSAMPLE`, 16: clocks per bit, at least 2.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  NUM_REQ: requester i has a byte.
- `req_data`  in  8*NUM_REQ: byte i is `req_data[8*i+7:8*i]`.
- `req_ready`  out  NUM_REQ: one-hot; the transfer happens on a cycle with `req_valid[i] && req_ready[i]`.
- `parity_config`  in  2: bit 1 enables parity; bit 0 selects parity type (1 = odd, 0 = even).
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: a frame is in flight.
- `grant_id`  out  $clog2(NUM_REQ): index of the last accepted requester.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, GUARD.
- Registers:
  - tick counter, 0..OVERSAMPLE-1
  - bit index, 0..7
  - shift register holding the captured byte
  - captured parity_config
  - round-robin pointer `rr`
- IDLE:
  - `req_ready` is driven combinationally, only in this state.
  - Winner = first i with `req_valid[i]`, searching `rr, rr+1, … rr+NUM_REQ-1` modulo NUM_REQ.
  - Only the winner's `req_ready` bit is high. All bits are low when no requester is valid.
- Handshake:
  - Capture `req_data[winner]` and `parity_config`.
  - Set `grant_id` = winner and `rr` = (winner+1) mod NUM_REQ.
  - Next state is START.
- Each non-IDLE state lasts exactly OVERSAMPLE cycles, counted by the tick counter.
- DATA runs 8 bit periods. The bit index increments on each tick wrap.
- After DATA:
  - go to PARITY if parity is enabled in the captured config,
  - otherwise go to STOP1.
- Then STOP1, STOP2, GUARD, and back to IDLE.
- `tx` value per state:
  - START: 0
  - DATA: `data[bit_index]`
  - PARITY: XOR of the 8 data bits, inverted when odd parity is selected
  - STOP1, STOP2, GUARD: 1
  - IDLE: 1
- `tx` is registered; there is no combinational path from inputs to `tx`.
- `busy` is 1 in every state except IDLE.
- Changes to `parity_config` or `req_data` after the handshake have no effect on the frame in flight.
- A requester may drop `req_valid` before it is granted; no byte is lost or duplicated as a result.
- A requester that is granted and re-asserts immediately gets lowest priority among the requesters then pending.

## Timing
- Let T be the handshake edge. "T+k" means the k-th rising edge after T.
- `tx` values are seen after edge T+k:
  - START: T+1..T+OS, where OS = OVERSAMPLE.
  - Data bit i: T+(1+i)·OS+1 .. T+(2+i)·OS.
- Frame length without parity is 12·OS cycles (192 at default):
  - STOP1 starts at T+9·OS+1.
  - GUARD ends at T+12·OS.
- With parity, PARITY is inserted after data and every later state shifts by OS. The frame is 13·OS cycles (208 at default).
- IDLE is re-entered one cycle after GUARD ends.
  - Earliest next handshake: T+12·OS+1, or T+13·OS+1 with parity.
  - This gives a back-to-back frame period of 193 cycles at default, 209 with parity.
- `busy` rises at T+1 and falls at the IDLE entry.
- Reset values with `rst_n` low at an edge:
  - `tx` = 1, `busy` = 0, `grant_id` = 0, `req_ready` = 0, `rr` = 0, counters = 0, state = IDLE.
- Reset mid-frame aborts the frame: `tx` is 1 after the reset edge. The aborted byte is not retransmitted.
- `req_ready` is 0 on every cycle where `rst_n` is low.

## Configuration
- `UART_TX_ARB_PARITY_EN`
  - Defined: parity support as described above.
  - Undefined:
    - The PARITY state and parity logic are compiled out.
    - `parity_config` is still present but ignored.
    - Every frame is 12·OVERSAMPLE cycles.

## Test plan
- Single frame:
  - Stimulus: req0 valid with 0xA5, parity off.
  - Response: `tx` = 0 for 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), then 1 for 48 clocks. `busy` is high for 192 cycles. `grant_id` = 0.
- Parity:
  - Stimulus: send 0x07 with `parity_config`=2'b10.
  - Response: parity bit = 1 in cycles 145..160 after T. With 2'b11 the parity bit is 0. Frame length is 208 in both cases. With the macro undefined, no parity bit appears and the frame is 192.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously.
  - Response: grant order 0,1,2,3,0. Each `req_ready` is a single-cycle pulse, and handshakes are 193 cycles apart.
- Fairness after re-request:
  - Stimulus: req2 and req3 valid. req2 is granted and re-asserts immediately.
  - Response: the next grant goes to req3, then req2.
- Reset mid-frame:
  - Stimulus: pull `rst_n` low at T+50 for 3 cycles while req1 stays valid.
  - Response: `tx` = 1 and `busy` = 0 after the reset edge. `req_ready` is 0 during reset. A new handshake to req1 occurs on the first cycle after `rst_n` rises, and the full frame follows.
- Late data change:
  - Stimulus: change `req_data0` and `parity_config` at T+5.
  - Response: the transmitted bits match the value captured at T.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmit line
// between NUM_REQ byte producers. Frame format: start bit, 8 data bits LSB
// first, optional parity bit, two stop bits, one idle guard bit. Every bit
// is held for OVERSAMPLE clocks.
// Optional feature macro: UART_TX_ARB_PARITY_EN (parity bit support; when
// undefined, parity_config is ignored and frames never carry a parity bit).
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [1:0]                 parity_config,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_ARB_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_GUARD  = 3'd6
    } state_t;

`ifdef UART_TX_ARB_PARITY_EN
    // Parity of a byte; odd selects the inverted (odd) sense.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

    // Registers
    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [2:0]      r_bit;
    logic [7:0]      r_data;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_grant;
    logic            r_tx;
    logic            r_busy;
`ifdef UART_TX_ARB_PARITY_EN
    logic            r_par_en;
    logic            r_par_odd;
`else
    logic            w_unused_cfg;
    assign w_unused_cfg = ^parity_config;
`endif

    // Combinational signals
    state_t          w_state_next;
    logic [TW-1:0]   w_tick_next;
    logic [TW-1:0]   w_tick_inc;
    logic            w_tick_wrap;
    logic [2:0]      w_bit_next;
    logic            w_tx_next;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_onehot;
    logic            w_accept;
    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [IW:0]     w_raw;
    logic [IW:0]     w_sum;
    logic [IW:0]     w_rr_inc;
    logic [IW-1:0]   w_rr_next;

    assign w_tick_wrap = (r_tick == TW'(OVERSAMPLE - 1));
    assign w_tick_inc  = w_tick_wrap ? '0 : (r_tick + TW'(1));
    assign w_onehot    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_rr_inc    = {1'b0, w_winner} + (IW+1)'(1);
    assign w_rr_next   = (w_rr_inc == (IW+1)'(NUM_REQ)) ? '0 : w_rr_inc[IW-1:0];

    // Round-robin search: first valid requester starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_raw    = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_raw = {1'b0, r_rr} + (IW+1)'(k);
            w_sum = (w_raw >= (IW+1)'(NUM_REQ)) ? (w_raw - (IW+1)'(NUM_REQ)) : w_raw;
            if (!w_found && req_valid[w_sum[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IW-1:0];
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Frame FSM: next state, counters, next tx level and the handshake.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        w_tx_next    = 1'b1;
        w_req_ready  = '0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_next = '0;
                w_bit_next  = 3'd0;
                if (w_found && rst_n) begin
                    w_req_ready  = w_onehot;
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                w_tx_next   = 1'b0;
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    w_state_next = S_DATA;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                w_tx_next   = r_data[r_bit];
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    if (r_bit == 3'd7) begin
                        w_bit_next = 3'd0;
`ifdef UART_TX_ARB_PARITY_EN
                        w_state_next = r_par_en ? S_PARITY : S_STOP1;
`else
                        w_state_next = S_STOP1;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_bit_next = r_bit;
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: begin
                w_tx_next   = parity_bit(r_data, r_par_odd);
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    w_state_next = S_STOP1;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
`endif
            S_STOP1: begin
                w_tx_next   = 1'b1;
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    w_state_next = S_STOP2;
                end else begin
                    w_state_next = S_STOP1;
                end
            end
            S_STOP2: begin
                w_tx_next   = 1'b1;
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    w_state_next = S_GUARD;
                end else begin
                    w_state_next = S_STOP2;
                end
            end
            S_GUARD: begin
                w_tx_next   = 1'b1;
                w_tick_next = w_tick_inc;
                if (w_tick_wrap) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_GUARD;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
                w_bit_next   = 3'd0;
            end
        endcase
    end

    // State, counters and registered line outputs; tx/busy lag the state by one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_busy  <= (r_state != S_IDLE);
        end
    end

    // Capture byte, frame config, grant and round-robin pointer on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= 8'h00;
            r_rr      <= '0;
            r_grant   <= '0;
`ifdef UART_TX_ARB_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
`endif
        end else if (w_accept) begin
            r_data    <= req_data[8*w_winner +: 8];
            r_rr      <= w_rr_next;
            r_grant   <= w_winner;
`ifdef UART_TX_ARB_PARITY_EN
            r_par_en  <= parity_config[1];
            r_par_odd <= parity_config[0];
`endif
        end else begin
            r_data    <= r_data;
            r_rr      <= r_rr;
            r_grant   <= r_grant;
        end
    end

    assign req_ready = w_req_ready;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign grant_id  = r_grant;

endmodule
